// File: rtl/chip_74194n_emu.sv
// ---------------------------------------------------------------------------
// chip_74194n_emu
// Emulates a 74194 4-bit bidirectional universal shift register. The tester
// drives the chip pins asynchronously to Clk, including the chip clock on
// Pin11. Pins go through a two-flop synchronizer. Chip-clock rising edges
// are found with a third flop on Pin11.
//
// Ports
//   Clk, Reset           system clock, async active-low reset
//   Run, DISP_RSLT       session control (arm / end session)
//   Pin1                 CLR_n
//   Pin2, Pin7           SR / SL serial inputs
//   Pin3..Pin6           parallel data A..D
//   Pin9, Pin10          mode select S0 / S1
//   Pin11                emulated chip clock
//   Pin15..Pin12         QA..QD, straight from flops
//   Active               high while a session is running
//   EdgeCount            accepted Pin11 edges this session, saturating at 255
// ---------------------------------------------------------------------------
module chip_74194n_emu (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       DISP_RSLT,
    input  logic       Pin1,
    input  logic       Pin2,
    input  logic       Pin3,
    input  logic       Pin4,
    input  logic       Pin5,
    input  logic       Pin6,
    input  logic       Pin7,
    input  logic       Pin9,
    input  logic       Pin10,
    input  logic       Pin11,
    output logic       Pin15,
    output logic       Pin14,
    output logic       Pin13,
    output logic       Pin12,
    output logic       Active,
    output logic [7:0] EdgeCount
);

    typedef enum logic {HALTED = 1'b0, ACTIVE = 1'b1} state_t;

    // Synchronizer bit positions
    localparam int B_CLR = 0;
    localparam int B_SR  = 1;
    localparam int B_A   = 2;
    localparam int B_B   = 3;
    localparam int B_C   = 4;
    localparam int B_D   = 5;
    localparam int B_SL  = 6;
    localparam int B_S0  = 7;
    localparam int B_S1  = 8;
    localparam int B_CK  = 9;

    state_t     state_q, state_d;
    logic [9:0] s1_q, s1_d, s2_q, s2_d;
    logic       s3_q, s3_d;
    logic [3:0] q_q, q_d;      // [3]=QA ... [0]=QD
    logic [7:0] cnt_q, cnt_d;
    logic       ck_edge;

    always_comb begin
        s1_d = {Pin11, Pin10, Pin9, Pin7, Pin6, Pin5, Pin4, Pin3, Pin2, Pin1};
        s2_d = s1_q;
        s3_d = s2_q[B_CK];
    end

    assign ck_edge = s2_q[B_CK] & ~s3_q;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        case (state_q)
            HALTED: begin
                // Edges are ignored here. Q and the count stay zero, so a new
                // session starts clean.
                q_d   = 4'b0000;
                cnt_d = 8'd0;
                if (Run) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (DISP_RSLT) begin
                    // An ending session clears on the same edge and drops any
                    // edge that coincides with it.
                    state_d = HALTED;
                    q_d     = 4'b0000;
                    cnt_d   = 8'd0;
                end else begin
                    // Edges count even when clear or hold makes them no-ops.
                    if (ck_edge && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                    if (!s2_q[B_CLR]) begin
                        q_d = 4'b0000;               // level-sensitive clear
                    end else if (ck_edge) begin
                        case ({s2_q[B_S1], s2_q[B_S0]})
                            2'b01:   q_d = {s2_q[B_SR], q_q[3:1]};
                            2'b10:   q_d = {q_q[2:0], s2_q[B_SL]};
                            2'b11:   q_d = {s2_q[B_A], s2_q[B_B], s2_q[B_C], s2_q[B_D]};
                            default: q_d = q_q;
                        endcase
                    end
                end
            end
            default: state_d = HALTED;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= HALTED;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= 1'b0;
            q_q     <= 4'b0000;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Pin15     = q_q[3];
    assign Pin14     = q_q[2];
    assign Pin13     = q_q[1];
    assign Pin12     = q_q[0];
    assign Active    = (state_q == ACTIVE);
    assign EdgeCount = cnt_q;

endmodule

// File: tb/tb_chip_74194n_emu.sv
// ---------------------------------------------------------------------------
// tb_chip_74194n_emu
// Directed scenarios for load, shift, hold, clear, saturation, session
// control and reset. These are followed by randomized pin activity, which is
// compared against a reference model. The model works on the history of
// sampled pin values: an edge is an accepted 0->1 of Pin11 between the
// samples taken two and three Clk edges ago.
// ---------------------------------------------------------------------------
module tb_chip_74194n_emu;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Run = 1'b0;
    logic       DISP_RSLT = 1'b0;
    logic       Pin1 = 1'b1, Pin2 = 1'b0, Pin3 = 1'b0, Pin4 = 1'b0, Pin5 = 1'b0;
    logic       Pin6 = 1'b0, Pin7 = 1'b0, Pin9 = 1'b0, Pin10 = 1'b0, Pin11 = 1'b0;
    logic       Pin15, Pin14, Pin13, Pin12, Active;
    logic [7:0] EdgeCount;
    logic [3:0] q_obs;

    int checks = 0;
    int errors = 0;

    chip_74194n_emu dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .DISP_RSLT(DISP_RSLT),
        .Pin1(Pin1), .Pin2(Pin2), .Pin3(Pin3), .Pin4(Pin4), .Pin5(Pin5),
        .Pin6(Pin6), .Pin7(Pin7), .Pin9(Pin9), .Pin10(Pin10), .Pin11(Pin11),
        .Pin15(Pin15), .Pin14(Pin14), .Pin13(Pin13), .Pin12(Pin12),
        .Active(Active), .EdgeCount(EdgeCount)
    );

    always #5 Clk = ~Clk;
    assign q_obs = {Pin15, Pin14, Pin13, Pin12};   // QA..QD

    // ---------------- reference model ----------------
    typedef struct packed {
        logic ck, s1, s0, sl, d, c, b, a, sr, clr;
    } smp_t;

    typedef struct packed {
        logic       act;
        logic [3:0] q;      // QA..QD
        logic [7:0] cnt;
        smp_t       h0;     // pins sampled three Clk edges ago
        smp_t       h1;     // two edges ago
        smp_t       h2;     // one edge ago
    } mst_t;

    mst_t m = '0;

    function automatic mst_t step(input mst_t s, input smp_t now,
                                  input logic run, input logic disp);
        mst_t n = s;
        bit   edge_seen = s.h1.ck && !s.h0.ck;
        int   mode = s.h1.s1 * 2 + s.h1.s0;
        if (!s.act) begin
            n.q = 0; n.cnt = 0;
            if (run) n.act = 1;
        end else if (disp) begin
            n.act = 0; n.q = 0; n.cnt = 0;
        end else begin
            if (edge_seen && s.cnt < 255) n.cnt = s.cnt + 1;
            if (!s.h1.clr) n.q = 0;
            else if (edge_seen) begin
                if (mode == 1)      n.q = (s.q >> 1) + (s.h1.sr ? 8 : 0);
                else if (mode == 2) n.q = ((s.q * 2) % 16) + (s.h1.sl ? 1 : 0);
                else if (mode == 3) n.q = s.h1.a * 8 + s.h1.b * 4 + s.h1.c * 2 + s.h1.d;
            end
        end
        n.h0 = s.h1; n.h1 = s.h2; n.h2 = now;
        return n;
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) m <= '0;
        else m <= step(m, '{ck: Pin11, s1: Pin10, s0: Pin9, sl: Pin7, d: Pin6,
                            c: Pin5, b: Pin4, a: Pin3, sr: Pin2, clr: Pin1},
                       Run, DISP_RSLT);
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_pins(input logic clr, input logic sr, input logic sl,
                              input logic [1:0] mode, input logic [3:0] abcd);
        Pin1 = clr; Pin2 = sr; Pin7 = sl;
        {Pin10, Pin9} = mode;
        {Pin3, Pin4, Pin5, Pin6} = abcd;
    endtask

    // Starts and ends on a falling Clk edge, with Q settled afterwards.
    task automatic pulse();
        Pin11 = 1'b1;
        repeat (4) @(negedge Clk);
        Pin11 = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic start_session();
        Run = 1'b1;
        @(negedge Clk);
        Run = 1'b0;
        checks++;
        if (Active !== 1'b1 || EdgeCount !== 8'd0 || q_obs !== 4'b0000) begin
            errors++;
            $display("FAIL session_start: Active=%b cnt=%0d Q=%b, want 1 0 0000", Active, EdgeCount, q_obs);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge Clk);
        checks++;
        if (q_obs !== 4'b0000 || Active !== 1'b0 || EdgeCount !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: Q=%b Active=%b cnt=%0d, want 0000 0 0", q_obs, Active, EdgeCount);
        end
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        checks++;
        if (Active !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: Active=%b want 0", Active);
        end
    endtask

    task automatic test_load();
        start_session();
        drive_pins(1'b1, 1'b0, 1'b0, 2'b11, 4'b1010);
        @(negedge Clk);
        Pin11 = 1'b1;
        @(negedge Clk);             // sampled high here (edge k+1)
        @(negedge Clk);             // edge k+2
        checks++;
        if (q_obs !== 4'b0000) begin
            errors++;
            $display("FAIL load_early: Q=%b want 0000 before k+3", q_obs);
        end
        @(negedge Clk);             // edge k+3
        checks++;
        if (q_obs !== 4'b1010 || EdgeCount !== 8'd1) begin
            errors++;
            $display("FAIL load: Q=%b cnt=%0d, want 1010 1", q_obs, EdgeCount);
        end
        Pin11 = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic test_shift_right();
        logic [3:0] exp_q [4] = '{4'b1101, 4'b1110, 4'b1111, 4'b1111};
        drive_pins(1'b1, 1'b1, 1'b0, 2'b01, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            pulse();
            checks++;
            if (q_obs !== exp_q[i]) begin
                errors++;
                $display("FAIL shift_right[%0d]: Q=%b want %b", i, q_obs, exp_q[i]);
            end
        end
        checks++;
        if (EdgeCount !== 8'd5) begin
            errors++;
            $display("FAIL shift_right_count: cnt=%0d want 5", EdgeCount);
        end
    endtask

    task automatic test_shift_left_hold();
        logic [3:0] exp_q [3] = '{4'b0010, 4'b0100, 4'b1000};
        drive_pins(1'b1, 1'b0, 1'b0, 2'b11, 4'b0001);
        pulse();
        drive_pins(1'b1, 1'b0, 1'b0, 2'b10, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            pulse();
            checks++;
            if (q_obs !== exp_q[i]) begin
                errors++;
                $display("FAIL shift_left[%0d]: Q=%b want %b", i, q_obs, exp_q[i]);
            end
        end
        drive_pins(1'b1, 1'b1, 1'b1, 2'b00, 4'b0110);
        for (int i = 0; i < 2; i++) begin
            pulse();
            checks++;
            if (q_obs !== 4'b1000) begin
                errors++;
                $display("FAIL hold[%0d]: Q=%b want 1000", i, q_obs);
            end
        end
        checks++;
        if (EdgeCount !== 8'd11) begin
            errors++;
            $display("FAIL left_hold_count: cnt=%0d want 11", EdgeCount);
        end
    endtask

    task automatic test_clear();
        drive_pins(1'b1, 1'b0, 1'b0, 2'b11, 4'b1111);
        pulse();
        drive_pins(1'b0, 1'b0, 1'b0, 2'b11, 4'b0101);
        pulse();
        checks++;
        if (q_obs !== 4'b0000 || EdgeCount !== 8'd13) begin
            errors++;
            $display("FAIL clear_priority: Q=%b cnt=%0d, want 0000 13", q_obs, EdgeCount);
        end
        Pin1 = 1'b1;
        repeat (5) @(negedge Clk);
        checks++;
        if (q_obs !== 4'b0000) begin
            errors++;
            $display("FAIL clear_release: Q=%b want 0000 without an edge", q_obs);
        end
        pulse();
        checks++;
        if (q_obs !== 4'b0101 || EdgeCount !== 8'd14) begin
            errors++;
            $display("FAIL clear_reload: Q=%b cnt=%0d, want 0101 14", q_obs, EdgeCount);
        end
    endtask

    task automatic test_saturate_and_halt();
        drive_pins(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000);
        for (int i = 0; i < 300; i++) pulse();
        checks++;
        if (EdgeCount !== 8'd255 || q_obs !== 4'b0101) begin
            errors++;
            $display("FAIL saturate: cnt=%0d Q=%b, want 255 0101", EdgeCount, q_obs);
        end
        DISP_RSLT = 1'b1;
        @(negedge Clk);
        DISP_RSLT = 1'b0;
        checks++;
        if (Active !== 1'b0 || q_obs !== 4'b0000 || EdgeCount !== 8'd0) begin
            errors++;
            $display("FAIL disp_rslt: Active=%b Q=%b cnt=%0d, want 0 0000 0", Active, q_obs, EdgeCount);
        end
        drive_pins(1'b1, 1'b0, 1'b0, 2'b11, 4'b1111);
        repeat (3) pulse();
        checks++;
        if (Active !== 1'b0 || q_obs !== 4'b0000 || EdgeCount !== 8'd0) begin
            errors++;
            $display("FAIL halted_edges: Active=%b Q=%b cnt=%0d, want 0 0000 0", Active, q_obs, EdgeCount);
        end
    endtask

    task automatic test_async_reset();
        start_session();
        drive_pins(1'b1, 1'b0, 1'b0, 2'b11, 4'b1010);
        pulse();
        checks++;
        if (q_obs !== 4'b1010) begin
            errors++;
            $display("FAIL pre_reset_load: Q=%b want 1010", q_obs);
        end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if (q_obs !== 4'b0000 || Active !== 1'b0 || EdgeCount !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: Q=%b Active=%b cnt=%0d, want 0000 0 0", q_obs, Active, EdgeCount);
        end
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    // Pin11 held high through reset creates one edge right after release.
    task automatic test_reset_pin11_high(input bit arm_now);
        Reset = 1'b0;
        drive_pins(1'b1, 1'b0, 1'b0, 2'b11, 4'b0110);
        Pin11 = 1'b1;
        @(negedge Clk);
        Reset = 1'b1;
        Run = arm_now;
        @(negedge Clk);
        Run = 1'b0;
        repeat (4) @(negedge Clk);
        if (!arm_now) start_session();
        checks++;
        if (arm_now && (q_obs !== 4'b0110 || EdgeCount !== 8'd1)) begin
            errors++;
            $display("FAIL reset_edge_active: Q=%b cnt=%0d, want 0110 1", q_obs, EdgeCount);
        end else if (!arm_now && (q_obs !== 4'b0000 || EdgeCount !== 8'd0)) begin
            errors++;
            $display("FAIL reset_edge_halted: Q=%b cnt=%0d, want 0000 0", q_obs, EdgeCount);
        end
        Pin11 = 1'b0;
        DISP_RSLT = 1'b1;
        @(negedge Clk);
        DISP_RSLT = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            checks++;
            if (Active !== m.act || q_obs !== m.q || EdgeCount !== m.cnt) begin
                errors++;
                $display("FAIL random[%0d]: Active=%b Q=%b cnt=%0d, want %b %b %0d",
                         i, Active, q_obs, EdgeCount, m.act, m.q, m.cnt);
            end
            if ($urandom_range(0, 399) == 0) begin
                Reset = 1'b0;
                #1;
                checks++;
                if (Active !== 1'b0 || q_obs !== 4'b0000 || EdgeCount !== 8'd0) begin
                    errors++;
                    $display("FAIL random_reset[%0d]: Active=%b Q=%b cnt=%0d, want 0 0000 0",
                             i, Active, q_obs, EdgeCount);
                end
                Reset = 1'b1;
            end
            Pin1  = ($urandom_range(0, 7) != 0);
            {Pin2, Pin3, Pin4, Pin5, Pin6, Pin7, Pin9, Pin10} = 8'($urandom);
            Pin11 = 1'($urandom);
            Run = ($urandom_range(0, 7) == 0);
            DISP_RSLT = ($urandom_range(0, 59) == 0);
            @(negedge Clk);
        end
        Run = 1'b0;
        DISP_RSLT = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift_right();
        test_shift_left_hold();
        test_clear();
        test_saturate_and_halt();
        test_async_reset();
        test_reset_pin11_high(1'b1);
        test_reset_pin11_high(1'b0);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
